// File: rtl/fetch_unit.sv
// PC register and single-outstanding instruction fetch stage. Holds one fetched
// instruction for decode and squashes in-flight fetches on redirect.
module fetch_unit #(
  parameter int                 XLEN     = 32,
  parameter logic [XLEN-1:0]    RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0]    NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_next_i,
  input  logic            redirect_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic [XLEN-1:0] inst_q, inst_n;
  logic            vld_q, vld_n;
  logic            drop, drop_n;
  logic [XLEN-1:0] pc_load;

  assign pc_load = {pc_next_i[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc_q   <= RESET_PC;
      inst_q <= NOP_INST;
      vld_q  <= 1'b0;
      drop   <= 1'b0;
    end else begin
      state  <= state_n;
      pc_q   <= pc_n;
      inst_q <= inst_n;
      vld_q  <= vld_n;
      drop   <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    inst_n  = inst_q;
    vld_n   = vld_q;
    drop_n  = drop;
    // Redirect outranks every accept; the held instruction is squashed.
    if (redirect_i && state != S_IDLE) begin
      pc_n   = pc_load;
      inst_n = NOP_INST;
      vld_n  = 1'b0;
    end
    case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        if (imem_req_ready_i) begin
          state_n = S_WAIT;
          // The old-address request is already in flight; its data must be dropped.
          if (redirect_i) drop_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          if (imem_rsp_valid_i) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end else if (imem_rsp_valid_i) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            inst_n  = imem_rsp_data_i;
            vld_n   = 1'b1;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          state_n = S_REQ;
        end else if (vld_q && inst_ready_i) begin
          pc_n    = pc_load;
          inst_n  = NOP_INST;
          vld_n   = 1'b0;
          state_n = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign pc_plus4_o       = pc_q + XLEN'(4);
  assign imem_req_valid_o = (state == S_REQ);
  assign imem_req_addr_o  = pc_q;
  assign inst_valid_o     = vld_q;
  assign inst_o           = inst_q;
  assign inst_pc_o        = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a latency-randomized memory model drives the
// fetch port and a transaction-level model predicts what decode should see.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] pc_next_i = '0, pc_plus4_o, imem_req_addr_o, imem_rsp_data_i = '0;
  logic [31:0] inst_o, inst_pc_o;
  logic        redirect_i = 1'b0, imem_req_valid_o, imem_req_ready_i = 1'b0;
  logic        imem_rsp_valid_i = 1'b0, inst_valid_o, inst_ready_i = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_next_i(pc_next_i), .redirect_i(redirect_i),
    .pc_plus4_o(pc_plus4_o), .imem_req_valid_o(imem_req_valid_o),
    .imem_req_addr_o(imem_req_addr_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  // Reference model: fetch target PC, whether a fetch is in flight and still wanted,
  // and whether decode is being offered an instruction.
  bit          m_started, m_out, m_live, m_hold;
  logic [31:0] m_pc, m_data;

  function automatic bit m_req();
    return m_started && !m_out && !m_hold;
  endfunction

  task automatic model_reset();
    m_started = 0; m_out = 0; m_live = 0; m_hold = 0;
    m_pc = RESET_PC; m_data = NOP;
  endtask

  // Memory: one request at a time, response after a chosen number of cycles.
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  logic [31:0] reqs[$];

  int k_ready = 100, k_iready = 100, k_redir = 0, k_spur = 0, k_lat_min = 1, k_lat_max = 1;
  int rst_pend = 2;
  bit force_on = 0;
  logic [31:0] force_tgt = '0;

  task automatic check_outputs();
    chk("pc_plus4", pc_plus4_o, m_pc + 32'd4);
    chk("inst_pc", inst_pc_o, m_pc);
    chk("req_addr", imem_req_addr_o, m_pc);
    chk("req_valid", {31'b0, imem_req_valid_o}, {31'b0, m_req()});
    chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, m_hold});
    chk("inst", inst_o, m_hold ? m_data : NOP);
  endtask

  task automatic step();
    bit d_acc, d_fire, acc, rsp;
    logic [31:0] d_addr, nxt;
    @(negedge clk);
    check_outputs();
    if (rst_pend > 0) begin
      if (!rst) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
      end
      rst_pend--;
    end else rst = 1'b0;
    imem_req_ready_i = !mem_busy && ($urandom_range(99) < k_ready);
    inst_ready_i     = ($urandom_range(99) < k_iready);
    redirect_i       = force_on || ($urandom_range(99) < k_redir);
    pc_next_i        = force_on ? force_tgt : (redirect_i ? $urandom : m_pc + 32'd4);
    force_on = 0;
    d_fire = mem_busy && mem_cnt == 0;
    if (d_fire) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = word(mem_addr);
    end else begin
      imem_rsp_valid_i = !mem_busy && ($urandom_range(99) < k_spur);
      imem_rsp_data_i  = $urandom;
    end
    d_acc  = !rst && imem_req_valid_o && imem_req_ready_i;
    d_addr = imem_req_addr_o;
    @(posedge clk);
    if (d_fire) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (d_acc) begin
      mem_busy = 1;
      mem_addr = d_addr;
      mem_cnt  = $urandom_range(k_lat_max, k_lat_min) - 1;
      reqs.push_back(d_addr);
    end
    nxt = {pc_next_i[31:2], 2'b00};
    if (rst) model_reset();
    else if (!m_started) m_started = 1;
    else begin
      acc = m_req() && imem_req_ready_i;
      rsp = m_out && imem_rsp_valid_i;
      if (redirect_i) begin
        m_pc = nxt; m_hold = 0;
        if (acc) begin m_out = 1; m_live = 0; end
        else if (m_out) begin
          if (rsp) m_out = 0; else m_live = 0;
        end
      end else if (acc) begin
        m_out = 1; m_live = 1;
      end else if (rsp) begin
        m_out = 0;
        if (m_live) begin m_hold = 1; m_data = imem_rsp_data_i; end
      end else if (m_hold && inst_ready_i) begin
        m_hold = 0; m_pc = nxt;
      end
    end
    #1;
  endtask

  task automatic wait_hold(input int max);
    int n = 0;
    while (!m_hold && n < max) begin step(); n++; end
    chk("wait_hold", {31'b0, m_hold}, 32'd1);
  endtask

  task automatic wait_out(input int max);
    int n = 0;
    while (!(m_out && m_live) && n < max) begin step(); n++; end
    chk("wait_out", {31'b0, m_out}, 32'd1);
  endtask

  task automatic wait_acc(input int max);
    int n = 0, n0 = reqs.size();
    while (reqs.size() == n0 && n < max) begin step(); n++; end
    chk("wait_acc", {31'b0, reqs.size() > n0}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Straight-line fetch, 1-cycle memory, decode always ready.
    repeat (20) step();
    chk("seq_req0", reqs[0], 32'h0);
    chk("seq_req1", reqs[1], 32'h4);
    chk("seq_req2", reqs[2], 32'h8);

    // Decode stall in hold.
    k_iready = 0;
    wait_hold(20);
    repeat (5) step();
    k_iready = 100;
    repeat (4) step();

    // Redirect while holding.
    k_iready = 0;
    wait_hold(20);
    force_on = 1; force_tgt = 32'h100;
    step();
    chk("redir_hold_valid", {31'b0, inst_valid_o}, 32'd0);
    reqs.delete();
    k_iready = 100;
    wait_acc(20);
    chk("redir_hold_addr", reqs[0], 32'h100);

    // Redirect while waiting on a 3-cycle response.
    k_lat_min = 3; k_lat_max = 3;
    wait_out(20);
    force_on = 1; force_tgt = 32'h200;
    step();
    reqs.delete();
    wait_acc(20);
    chk("redir_wait_addr", reqs[0], 32'h200);
    wait_hold(20);
    chk("redir_wait_pc", inst_pc_o, 32'h200);
    chk("redir_wait_inst", inst_o, word(32'h200));

    // Address wrap with a stalled memory port; low redirect bits are cleared.
    k_lat_min = 1; k_lat_max = 1; k_iready = 0;
    wait_hold(20);
    k_ready = 0;
    force_on = 1; force_tgt = 32'hFFFF_FFFF;
    step();
    repeat (4) begin
      step();
      chk("wrap_addr", imem_req_addr_o, 32'hFFFF_FFFC);
      chk("wrap_plus4", pc_plus4_o, 32'h0);
    end
    k_ready = 100; k_iready = 100;
    reqs.delete();
    wait_acc(20);
    wait_acc(20);
    chk("wrap_first", reqs[0], 32'hFFFF_FFFC);
    chk("wrap_next", reqs[1], 32'h0);

    // Reset while a slow response is pending; it lands after release.
    k_lat_min = 6; k_lat_max = 6;
    wait_out(20);
    rst_pend = 2;
    repeat (3) step();
    reqs.delete();
    wait_acc(30);
    chk("rst_first_req", reqs[0], RESET_PC);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) begin
        k_ready = $urandom_range(100, 20); k_iready = $urandom_range(100, 20);
        k_redir = $urandom_range(25); k_spur = $urandom_range(40);
        k_lat_min = $urandom_range(3, 1); k_lat_max = k_lat_min + $urandom_range(3);
      end
      if ($urandom_range(499) == 0) rst_pend = $urandom_range(3, 1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the 32-bit core.
- Holds the architectural PC and issues single-outstanding fetch requests to instruction memory.
- Presents each fetched instruction to decode with a valid/ready handshake.
- Exports pc_plus4_o, which drives I0 of the PC-select 2:1 mux. It consumes that mux's output as pc_next_i, with redirect_i tied to the mux select.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Bits [1:0] must be 0.
- NOP_INST, 32'h0000_0013, value of inst_o while no instruction is held.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_next_i  input  XLEN  next PC from the PC-select mux output.
- redirect_i  input  1  branch/jump taken; same signal as the mux select.
- pc_plus4_o  output  XLEN  pc_q + 4; drives mux I0.
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_addr_o  output  XLEN  fetch address; equals pc_q.
- imem_req_ready_i  input  1  memory accepts the request.
- imem_rsp_valid_i  input  1  fetch data valid.
- imem_rsp_data_i  input  XLEN  fetched instruction word.
- inst_valid_o  output  1  instruction available to decode.
- inst_o  output  XLEN  held instruction.
- inst_pc_o  output  XLEN  PC of inst_o; equals pc_q.
- inst_ready_i  input  1  decode accepts the instruction. Deassert to stall.

Behaviour:
- State machine: S_IDLE, S_REQ, S_WAIT, S_HOLD. There is a separate 1-bit drop flag.
- Reset (asynchronous, any state):
  - state = S_IDLE, pc_q = RESET_PC, drop = 0.
  - inst_valid_o = 0, inst_o = NOP_INST, imem_req_valid_o = 0.
  - pc_plus4_o = RESET_PC + 4.
- S_IDLE: always moves to S_REQ on the first clock edge after rst deasserts.
- S_REQ:
  - imem_req_valid_o = 1 and imem_req_addr_o = pc_q, combinational from state.
  - Address is held stable until accepted.
  - When imem_req_ready_i = 1, go to S_WAIT.
- S_WAIT, on imem_rsp_valid_i:
  - If drop = 1: discard the data, clear drop, go to S_REQ.
  - Else: inst_o <= imem_rsp_data_i, inst_valid_o <= 1, go to S_HOLD.
- S_HOLD:
  - inst_valid_o = 1; inst_o and inst_pc_o are held stable.
  - On inst_valid_o & inst_ready_i: pc_q <= pc_next_i & ~3, inst_valid_o <= 0, inst_o <= NOP_INST, go to S_REQ.
- Fetch latency: first request is one cycle after reset release. Minimum 3 cycles from request accept to next request: WAIT, HOLD, then accept.
- imem_rsp_valid_i is ignored outside S_WAIT. This also covers stale responses to requests issued before a reset.
- Redirect (redirect_i = 1, any state except S_IDLE) has priority over accept:
  - pc_q <= pc_next_i & ~3; inst_valid_o <= 0; inst_o <= NOP_INST.
  - S_REQ with imem_req_ready_i = 0: stay in S_REQ. The new address appears next cycle.
  - S_REQ with imem_req_ready_i = 1 in the same cycle: the old-address request is in flight. Go to S_WAIT with drop = 1.
  - S_WAIT without rsp_valid: drop <= 1, stay in S_WAIT.
  - S_WAIT with rsp_valid in the same cycle: discard the response, drop <= 0, go to S_REQ.
  - S_HOLD: go to S_REQ. The held instruction is squashed.
  - A repeated redirect while drop = 1 keeps drop = 1 and reloads pc_q.
- Arithmetic and width rules:
  - pc_plus4_o = pc_q + 4, modulo 2^XLEN. 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - pc_q[1:0] is always 0; the low bits of pc_next_i are cleared on load.
- At most one request is outstanding. imem_req_valid_o is never asserted in S_WAIT or S_HOLD.

Test Plan:
- Reset with RESET_PC = 0, memory ready, 1-cycle latency, inst_ready = 1, redirect = 0 (pc_next_i = pc_plus4_o) -> requests at 0x0, 0x4, 0x8. inst_pc_o matches each address; pc_plus4_o = 0x4, 0x8, 0xC.
- Hold inst_ready_i = 0 for 5 cycles in S_HOLD -> inst_valid_o stays 1, inst_o/inst_pc_o stable, no new request. Release -> pc advances by exactly 4.
- Redirect to 0x100 while in S_HOLD at PC 0x8 -> inst_valid_o drops next cycle; next request address = 0x100; the 0x8 instruction is never accepted.
- Redirect to 0x200 in S_WAIT (response for 0x10 arrives 3 cycles later) -> the 0x10 data is discarded, inst_valid_o stays 0, next request = 0x200, and its data is presented with inst_pc_o = 0x200.
- imem_req_ready_i low for 4 cycles, then pc_q = 32'hFFFF_FFFC -> address stable throughout stall; pc_plus4_o = 0x0; after accept, next fetch = 0x0.
- Assert rst in S_WAIT, then deliver the stale rsp_valid after release -> outputs return to reset values; the stale response is ignored; first post-reset request = RESET_PC.
